// File: rtl/pooling_max_unit_if.sv
// Lane bus between the systolic-array columns / pooling controller and pooling_max_unit.
// master drives strobes and data; slave (the pooling unit) returns the pooled words and strobes.
interface pooling_max_unit_if #(
    parameter int COLS   = 4,
    parameter int DATA_W = 16
);
    logic [COLS-1:0]        pooling_signal_i;
    logic [COLS-1:0]        input_flag_pl_i;
    logic [COLS*DATA_W-1:0] din;
    logic [COLS*DATA_W-1:0] dout;
    logic                   dout_valid;
    logic                   out_flag_pooling;
    logic                   period_done;

    modport master (
        output pooling_signal_i, input_flag_pl_i, din,
        input  dout, dout_valid, out_flag_pooling, period_done
    );

    modport slave (
        input  pooling_signal_i, input_flag_pl_i, din,
        output dout, dout_valid, out_flag_pooling, period_done
    );
endinterface

// File: rtl/pooling_max_unit.sv
// Per-column KxK max pooling with window/period handshaking toward the pooling controller.
// Optional macro POOL_RELU_EN clamps negative pooled results to zero at emit time.
module pooling_max_unit #(
    parameter int COLS   = 4,
    parameter int DATA_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pooling_en,
    input  logic [1:0] cnt_pl_kernel_x,
    input  logic [1:0] cnt_pl_kernel_y,
    input  logic [3:0] cnt_pl_window,
    input  logic [2:0] POOLING_KERNEL_DIM,
    input  logic [2:0] POOLING_WINDOW_PER_PERIOD,
    pooling_max_unit_if.slave pl
);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, REQ} state_t;

    state_t state_q, state_d;

    logic [1:0] kx_q, ky_q;
    logic [3:0] win_q;
    logic       last_q, last_d;

    logic signed [DATA_W-1:0] acc_q [COLS];
    logic signed [DATA_W-1:0] acc_d [COLS];
    logic [COLS*DATA_W-1:0]   dout_q, dout_d;

    logic [COLS-1:0] hit;
    logic            first_smp;
    logic            win_end;
    logic            take;
    logic            dout_valid_s, out_flag_s, period_done_s;

    function automatic logic [DATA_W-1:0] post_pool(input logic signed [DATA_W-1:0] v);
`ifdef POOL_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign hit       = pl.input_flag_pl_i & pl.pooling_signal_i;
    assign first_smp = (kx_q == 2'd0) && (ky_q == 2'd0);
    assign win_end   = hit[0]
                    && ({1'b0, kx_q} == POOLING_KERNEL_DIM - 3'd1)
                    && ({1'b0, ky_q} == POOLING_KERNEL_DIM - 3'd1);

    always_comb begin
        logic signed [DATA_W-1:0] lane;
        lane = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            acc_d[c] = acc_q[c];
            lane     = pl.din[c*DATA_W +: DATA_W];
            if (hit[c] && (first_smp || (lane > acc_q[c]))) begin
                acc_d[c] = lane;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        take          = 1'b0;
        dout_valid_s  = 1'b0;
        out_flag_s    = 1'b0;
        period_done_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit[0]) begin
                    if (win_end) take = 1'b1;
                    else         state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (win_end) take = 1'b1;
            end
            EMIT: begin
                dout_valid_s  = 1'b1;
                period_done_s = last_q;
                state_d       = last_q ? IDLE : REQ;
            end
            REQ: begin
                out_flag_s = 1'b1;
                state_d    = ACCUM;
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = EMIT;
            last_d  = (win_q == {1'b0, POOLING_WINDOW_PER_PERIOD});
        end

        if (!pooling_en) begin
            state_d       = IDLE;
            take          = 1'b0;
            dout_valid_s  = 1'b0;
            out_flag_s    = 1'b0;
            period_done_s = 1'b0;
        end

        // dout is captured on the window-end edge so it is already stable in the EMIT cycle
        dout_d = dout_q;
        if (take) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                dout_d[c*DATA_W +: DATA_W] = post_pool(acc_d[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kx_q    <= '0;
            ky_q    <= '0;
            win_q   <= '0;
            last_q  <= 1'b0;
            dout_q  <= '0;
            for (int unsigned c = 0; c < COLS; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            kx_q    <= cnt_pl_kernel_x;
            ky_q    <= cnt_pl_kernel_y;
            win_q   <= cnt_pl_window;
            last_q  <= last_d;
            dout_q  <= dout_d;
            for (int unsigned c = 0; c < COLS; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign pl.dout             = dout_q;
    assign pl.dout_valid       = dout_valid_s;
    assign pl.out_flag_pooling = out_flag_s;
    assign pl.period_done      = period_done_s;

endmodule

// File: tb/tb_pooling_max_unit.sv
// Randomized bench for pooling_max_unit: per-window lane maxima from a queue model, strobe timing checks.
module tb_pooling_max_unit;
    localparam int COLS   = 4;
    localparam int DATA_W = 16;

    logic       clk;
    logic       rst_n;
    logic       pooling_en;
    logic [1:0] kx, ky;
    logic [3:0] win;
    logic [2:0] kdim, period;

    pooling_max_unit_if #(.COLS(COLS), .DATA_W(DATA_W)) bus ();

    pooling_max_unit #(.COLS(COLS), .DATA_W(DATA_W)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .pooling_en                (pooling_en),
        .cnt_pl_kernel_x           (kx),
        .cnt_pl_kernel_y           (ky),
        .cnt_pl_window             (win),
        .POOLING_KERNEL_DIM        (kdim),
        .POOLING_WINDOW_PER_PERIOD (period),
        .pl                        (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    int          vals [9][COLS];
    logic [3:0]  msk  [9];
    int          lastexp [COLS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.dout_valid === 1'b1) pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int lane_of(input int c);
        logic signed [DATA_W-1:0] v;
        v = bus.dout[c*DATA_W +: DATA_W];
        return int'(v);
    endfunction

    function automatic int pooled(input int v);
`ifdef POOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Counters go out one cycle before the flags they describe.
    task automatic send_sample(input int x, input int y, input int w, input int i);
        logic [3:0] r1, r2;
        kx  = 2'(x);
        ky  = 2'(y);
        win = 4'(w);
        bus.input_flag_pl_i  = '0;
        bus.pooling_signal_i = '0;
        @(posedge clk); #1;
        r1 = 4'($urandom);
        r2 = 4'($urandom);
        bus.input_flag_pl_i  = msk[i] | r1;
        bus.pooling_signal_i = msk[i] | (~r1 & r2);
        for (int c = 0; c < COLS; c++) bus.din[c*DATA_W +: DATA_W] = DATA_W'(vals[i][c]);
        @(posedge clk); #1;
        bus.input_flag_pl_i  = '0;
        bus.pooling_signal_i = '0;
        bus.din = {COLS{16'hdead}};
    endtask

    task automatic fill(input int k, input bit rnd);
        for (int i = 0; i < k*k; i++) begin
            msk[i] = (i == 0) ? 4'hf : (rnd ? (4'($urandom) | 4'h1) : 4'hf);
            for (int c = 0; c < COLS; c++) vals[i][c] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic run_window(input int k, input int w, input int per, input string tag);
        int p0;
        int ex [COLS];
        int q [$];
        p0 = pulses;
        for (int c = 0; c < COLS; c++) begin
            q = {};
            for (int i = 0; i < k*k; i++) if (msk[i][c]) q.push_back(vals[i][c]);
            ex[c] = q[0];
            foreach (q[j]) if (q[j] > ex[c]) ex[c] = q[j];
        end
        kdim   = 3'(k);
        period = 3'(per);
        for (int i = 0; i < k*k; i++) send_sample(i % k, i / k, w, i);
        check({tag, "_valid"}, bus.dout_valid, 1);
        check({tag, "_pdone"}, bus.period_done, (w == per) ? 1 : 0);
        check({tag, "_flag_emit"}, bus.out_flag_pooling, 0);
        for (int c = 0; c < COLS; c++) begin
            check($sformatf("%s_dout%0d", tag, c), lane_of(c), pooled(ex[c]));
            lastexp[c] = pooled(ex[c]);
        end
        @(posedge clk); #1;
        check({tag, "_valid_off"}, bus.dout_valid, 0);
        check({tag, "_flag_req"}, bus.out_flag_pooling, (w == per) ? 0 : 1);
        check({tag, "_npulse"}, pulses - p0, 1);
    endtask

    initial begin
        int w, per, k;
        rst_n = 1'b0;
        pooling_en = 1'b1;
        kx = '0; ky = '0; win = '0; kdim = 3'd2; period = 3'd0;
        bus.input_flag_pl_i  = '0;
        bus.pooling_signal_i = '0;
        bus.din = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.dout_valid, 0);
        check("rst_flag", bus.out_flag_pooling, 0);
        check("rst_pdone", bus.period_done, 0);
        check("rst_dout", bus.dout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // K=2 single-window period
        fill(2, 1'b0);
        vals[0][0] = 5; vals[1][0] = -3; vals[2][0] = 9; vals[3][0] = 2;
        run_window(2, 0, 0, "k2p0");

        // K=2 two windows, stride 2
        fill(2, 1'b0);
        for (int i = 0; i < 4; i++) vals[i][1] = i + 1;
        run_window(2, 0, 2, "k2w0");
        fill(2, 1'b0);
        for (int i = 0; i < 4; i++) vals[i][1] = i - 8;
        run_window(2, 2, 2, "k2w2");

        // K=3 ramps
        fill(3, 1'b0);
        for (int i = 0; i < 9; i++) for (int c = 0; c < COLS; c++) vals[i][c] = c*10 + i;
        run_window(3, 0, 0, "k3ramp");

        // K=1 every sample ends a window
        fill(1, 1'b0); vals[0][0] = 7;  run_window(1, 0, 2, "k1a");
        fill(1, 1'b0); vals[0][0] = 0;  run_window(1, 1, 2, "k1b");
        fill(1, 1'b0); vals[0][0] = -1; run_window(1, 2, 2, "k1c");

        // Reset mid-window
        fill(2, 1'b0);
        for (int c = 0; c < COLS; c++) begin vals[0][c] = 100; vals[1][c] = 200; end
        kdim = 3'd2; period = 3'd0;
        send_sample(0, 0, 0, 0);
        send_sample(1, 0, 0, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_dout", bus.dout, 0);
        check("midrst_valid", bus.dout_valid, 0);
        fill(2, 1'b0);
        vals[0][0] = 4; vals[1][0] = 1; vals[2][0] = 1; vals[3][0] = 1;
        run_window(2, 0, 0, "postrst");

        // pooling_en dropped mid-window
        begin
            int p0;
            fill(2, 1'b0);
            p0 = pulses;
            send_sample(0, 0, 0, 0);
            send_sample(1, 0, 0, 1);
            pooling_en = 1'b0;
            @(posedge clk); #1;
            check("endrop_valid", bus.dout_valid, 0);
            send_sample(0, 1, 0, 2);
            send_sample(1, 1, 0, 3);
            @(posedge clk); #1;
            check("endrop_npulse", pulses - p0, 0);
            check("endrop_flag", bus.out_flag_pooling, 0);
            for (int c = 0; c < COLS; c++) check($sformatf("endrop_dout%0d", c), lane_of(c), lastexp[c]);
            pooling_en = 1'b1;
            @(posedge clk); #1;
        end

        // Randomized periods
        for (int p = 0; p < 6; p++) begin
            k   = int'($urandom_range(1, 3));
            per = int'($urandom_range(0, 3));
            w   = 0;
            while (w <= per) begin
                fill(k, 1'b1);
                run_window(k, w, per, $sformatf("rnd%0d_%0d", p, w));
                w++;
            end
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pooling_max_unit.md
Name: pooling_max_unit

Overview:
- Receive-side datapath for the pooling controller's flag/counter interface.
- Consumes per-column input_flag / pooling_signal strobes and the kernel/window counters, and max-reduces each KxK window of the per-column PE result stream.
- Emits one pooled word per column per window.
- Returns out_flag_pooling to the controller to request the next window; sits between the systolic-array column outputs and the feature-map write-back buffer.

Parameters:
- COLS, 4, number of array columns (independent lanes).
- DATA_W, 16, signed data width per lane.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pooling_en  in  1  layer uses pooling; 0 forces IDLE
- pooling_signal_i  in  COLS  per-column pooling-active strobe from controller
- input_flag_pl_i  in  COLS  per-column sample-valid strobe from controller
- cnt_pl_kernel_x  in  2  kernel x index (one cycle ahead of the flags)
- cnt_pl_kernel_y  in  2  kernel y index (one cycle ahead of the flags)
- cnt_pl_window  in  4  window position (one cycle ahead of the flags)
- POOLING_KERNEL_DIM  in  3  K, legal 1..3
- POOLING_WINDOW_PER_PERIOD  in  3  last window position of a period
- din  in  COLS*DATA_W  lane c at bits [c*DATA_W +: DATA_W], signed
- dout  out  COLS*DATA_W  pooled max per lane
- dout_valid  out  1  one-cycle strobe, dout valid
- out_flag_pooling  out  1  one-cycle request for next window
- period_done  out  1  one-cycle strobe after the last window of a period

Behaviour:
- Reset: synchronous on rst_n=0 at a clk edge. dout=0, dout_valid=0, out_flag_pooling=0, period_done=0, all accumulators=0, state=IDLE. Reset mid-window discards partial results with no output strobe.
- Alignment: cnt_pl_kernel_x/y and cnt_pl_window pass through one internal register stage, so they are aligned with input_flag_pl_i/pooling_signal_i (which arrive one cycle later than the counters).
- Per lane c, on a cycle with input_flag_pl_i[c]=1 and pooling_signal_i[c]=1:
  - aligned kx==0 && ky==0: acc[c] <= din[c] (load).
  - otherwise: acc[c] <= max(acc[c], din[c]), signed compare.
  - Lanes with the flag low hold acc.
- Window end is the lane-0 sample with aligned kx==K-1 && ky==K-1.
- FSM states:
  - IDLE -> ACCUM on the first lane-0 flag with pooling_en=1.
  - ACCUM -> EMIT on window end.
  - EMIT lasts 1 cycle: dout <= final acc of every lane (including the window-end sample), dout_valid=1.
    - If the aligned window == POOLING_WINDOW_PER_PERIOD: period_done=1 that cycle, -> IDLE.
    - Else -> REQ.
  - REQ lasts 1 cycle: out_flag_pooling=1, -> ACCUM.
- Latency: dout_valid is 1 cycle after the window-end sample; out_flag_pooling is 2 cycles after it.
- dout holds its value until the next EMIT.
- K=1: every sample is a window end.
- pooling_en=0 in any state: -> IDLE next cycle, all strobes 0, dout held.
- A flag arriving in EMIT/REQ is a protocol error. It is still accumulated (load/max rule), and the FSM does not re-enter ACCUM early.
- Window counter wrap is owned by the controller; no internal window count.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: the EMIT stage clamps each lane, dout[c] = (acc[c] < 0) ? 0 : acc[c], giving fused ReLU after pooling. Timing is unchanged.
- Undefined: dout[c] = acc[c], signed values pass through.

Test Plan:
- K=2, period=0, lane0 samples 5,-3,9,2 -> dout lane0=9, dout_valid 1 cycle after the 4th sample, period_done high that cycle, out_flag_pooling never asserted.
- K=2, period=2, stride 2, two windows lane1 {1,2,3,4} then {-8,-7,-6,-5} -> dout 4 then -5 (0 with POOL_RELU_EN); out_flag_pooling once, 2 cycles after the first window end.
- K=3, all 4 lanes with distinct ramps (lane c sample i = c*10+i) -> dout lanes {8,18,28,38}.
- K=1, three samples 7,0,-1, period=2, stride=1 -> three dout_valid strobes with 7,0,-1 (0 under POOL_RELU_EN).
- rst_n=0 for 1 cycle after 2 of 4 samples, then a full window {4,1,1,1} -> only one dout_valid with 4; no stale max from pre-reset data.
- pooling_en dropped mid-ACCUM -> next cycle IDLE, no dout_valid, dout unchanged.
